clk_set_ctrl: RTL and testbench
===============================

# clk_set_ctrl

User-facing set-mode controller for the real-time clock. It turns three debounced push-button levels into an edit sequence: minutes first, then seconds. When the edit is committed, it issues a three-beat write sequence on the clock's `load`/`addrs`/`data_in` configuration bus: minutes, then seconds, then a time-base clear. It sits between the button synchronisers and the clock top, and watches the clock's live `seconds_out`/`minutes_out` to seed each edit.

## Interface
- `REPEAT_CYCLES`, default 25_000_000: cycles a held inc/dec button must stay high before each auto-repeat step.
- `TIMEOUT_CYCLES`, default 500_000_000: idle cycles in a SET state before the edit is abandoned (only with `CLK_SET_CTRL_TIMEOUT_EN`).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `btn_mode`  in  1  mode button level, already synchronised and debounced.
- `btn_inc`  in  1  increment button level.
- `btn_dec`  in  1  decrement button level.
- `seconds_in`  in  6  live seconds from the clock, 0..59.
- `minutes_in`  in  6  live minutes from the clock, 0..59.
- `load_out`  out  1  write strobe to the clock; single-cycle pulse per beat.
- `addrs_out`  out  2  write target: 2'b00 time base, 2'b01 seconds, 2'b10 minutes.
- `data_out`  out  6  write data.
- `editing`  out  1  high in SET_MIN and SET_SEC.
- `field_sel`  out  1  0 = minutes being edited, 1 = seconds being edited.
- `edit_value`  out  6  value of the field under edit, for display.

## Operation
- Edge detection:
  - press = `btn & ~btn_q`.
  - All `btn_q` registers reset to 1, so a button held through reset does not register as a press.
- States: RUN, SET_MIN, SET_SEC, WR_MIN, WR_SEC, WR_TB.
- RUN:
  - On a mode press: `edit_min <= minutes_in`, `edit_sec <= seconds_in`, go to SET_MIN.
  - inc/dec are ignored.
- SET_MIN / SET_SEC, applied to the active field:
  - inc press: value+1; 59 wraps to 0.
  - dec press: value-1; 0 wraps to 59.
  - inc and dec pressed, or both held, in the same cycle: no change and the repeat counter clears.
- Auto-repeat:
  - While exactly one of inc/dec stays held, the repeat counter counts.
  - On reaching `REPEAT_CYCLES-1` it applies one step and restarts from 0.
  - Release clears the counter.
- Mode press in SET_MIN goes to SET_SEC; mode press in SET_SEC goes to WR_MIN.
- A mode press takes priority over a simultaneous inc/dec: no field change in that cycle.
- Write beats (buttons ignored; one cycle each):
  - WR_MIN: `load_out=1`, `addrs_out=2'b10`, `data_out=edit_min`.
  - WR_SEC: `load_out=1`, `addrs_out=2'b01`, `data_out=edit_sec`.
  - WR_TB: `load_out=1`, `addrs_out=2'b00`, `data_out=0`; then go to RUN.
- Outside the write states: `load_out=0`, `addrs_out=2'b00`, `data_out=0`.
- The block never writes a value above 59. Out-of-range `seconds_in`/`minutes_in` seeds are clamped to 59 at capture.

## Timing
- Reset values: state RUN; `load_out=0`, `addrs_out=0`, `data_out=0`, `editing=0`, `field_sel=0`, `edit_value=0`; edit registers 0; repeat and timeout counters 0.
- All outputs are registered.
- A button rising at cycle t is seen as a press at t+1 (btn_q sampling). The state or value update is visible at t+2.
- Commit: the mode press in SET_SEC, seen at cycle p, produces `load_out` high at cycles p+1, p+2 and p+3 (minutes, seconds, time base). `editing` is low from p+1.
- `edit_value` tracks the active field with 1-cycle latency after the update.
- Reset asserted mid-write aborts the remaining beats. `load_out` is 0 on the cycle after reset is sampled.

## Configuration
- `CLK_SET_CTRL_TIMEOUT_EN` defined:
  - A timeout counter runs in SET_MIN/SET_SEC and clears on any press or on auto-repeat activity.
  - On reaching `TIMEOUT_CYCLES-1` the FSM returns to RUN with no write beats; the clock keeps its running time.
- Not defined: no timeout logic; SET states persist indefinitely.

## Test plan
- Reset held with `btn_inc=1`, then released → no press registered; all outputs 0; state RUN.
- `minutes_in=12`, `seconds_in=34`; mode, inc×3, mode, dec×1, mode → `load_out` beats: (2'b10, 15), (2'b01, 33), (2'b00, 0) on three consecutive cycles; then `editing=0`.
- Seed minutes 59, inc press → `edit_value=0`. Seed seconds 0 in SET_SEC, dec press → `edit_value=59`.
- `REPEAT_CYCLES=4`, hold `btn_inc` for 13 cycles in SET_MIN from 10 → 1 press step plus 3 repeat steps = 14; no change after release.
- inc and dec rising in the same cycle → `edit_value` unchanged. Mode and inc together in SET_MIN → `field_sel=1`, minutes unchanged.
- With `CLK_SET_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`: enter SET_MIN, 8 idle cycles → RUN, `load_out` never asserted. Without the macro → still in SET_MIN after 100 cycles.

Source files
------------

// File: rtl/clk_set_ctrl_if.sv
// Button/clock-config bus between the set-mode controller and its surroundings.
// slave: the controller itself. master: the button/clock side that drives it.
interface clk_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [5:0] seconds_in;
  logic [5:0] minutes_in;
  logic       load_out;
  logic [1:0] addrs_out;
  logic [5:0] data_out;
  logic       editing;
  logic       field_sel;
  logic [5:0] edit_value;

  modport slave (
    input  btn_mode, btn_inc, btn_dec, seconds_in, minutes_in,
    output load_out, addrs_out, data_out, editing, field_sel, edit_value
  );

  modport master (
    output btn_mode, btn_inc, btn_dec, seconds_in, minutes_in,
    input  load_out, addrs_out, data_out, editing, field_sel, edit_value
  );
endinterface

// File: rtl/clk_set_ctrl.sv
// clk_set_ctrl: push-button set-mode controller for the real-time clock.
// Edits minutes then seconds, then commits with three load beats
// (minutes, seconds, time-base clear).
// Optional feature macro: CLK_SET_CTRL_TIMEOUT_EN abandons an idle edit.
module clk_set_ctrl #(
  parameter int REPEAT_CYCLES  = 25_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic           clk,
  input  logic           reset,
  clk_set_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN, SET_MIN, SET_SEC, WR_MIN, WR_SEC, WR_TB
  } state_t;

  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  // Zero or negative cycle counts would make the counters meaningless.
  if (REPEAT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("clk_set_ctrl: REPEAT_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  function automatic logic [5:0] up59(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dn59(input logic [5:0] v);
    return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      btn_q;            // {mode, inc, dec} previous levels
  logic [2:0]      btn, press;
  logic [5:0]      edit_min_q, edit_min_d;
  logic [5:0]      edit_sec_q, edit_sec_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic            step_up, step_dn;
  logic            load_q;
  logic [1:0]      addrs_q;
  logic [5:0]      data_q;
  logic            editing_q, field_sel_q;
  logic [5:0]      edit_value_q;

`ifdef CLK_SET_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  assign btn   = {bus.btn_mode, bus.btn_inc, bus.btn_dec};
  assign press = btn & ~btn_q;

  // Next-state, field edits and auto-repeat counting.
  always_comb begin
    state_d    = state_q;
    edit_min_d = edit_min_q;
    edit_sec_d = edit_sec_q;
    rep_d      = '0;
    step_up    = 1'b0;
    step_dn    = 1'b0;
`ifdef CLK_SET_CTRL_TIMEOUT_EN
    to_d       = '0;
`endif
    case (state_q)
      RUN: begin
        if (press[2]) begin
          edit_min_d = clamp59(bus.minutes_in);
          edit_sec_d = clamp59(bus.seconds_in);
          state_d    = SET_MIN;
        end
      end
      SET_MIN, SET_SEC: begin
        if (press[2]) begin
          // mode wins over any simultaneous inc/dec
          state_d = (state_q == SET_MIN) ? SET_SEC : WR_MIN;
        end else if (btn[1] && btn[0]) begin
          // both held (or pressed together): hold value, counter stays clear
        end else if (press[1]) begin
          step_up = 1'b1;
        end else if (press[0]) begin
          step_dn = 1'b1;
        end else if (btn[1] ^ btn[0]) begin
          if (rep_q == REP_LAST) begin
            step_up = btn[1];
            step_dn = btn[0];
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
`ifdef CLK_SET_CTRL_TIMEOUT_EN
        // any press or held button counts as activity
        if (press == 3'b000 && !btn[1] && !btn[0]) begin
          if (to_q == TO_LAST) state_d = RUN;
          else                 to_d    = to_q + TW'(1);
        end
`endif
      end
      WR_MIN:  state_d = WR_SEC;
      WR_SEC:  state_d = WR_TB;
      WR_TB:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (state_q == SET_MIN) begin
      if (step_up) edit_min_d = up59(edit_min_q);
      if (step_dn) edit_min_d = dn59(edit_min_q);
    end else if (state_q == SET_SEC) begin
      if (step_up) edit_sec_d = up59(edit_sec_q);
      if (step_dn) edit_sec_d = dn59(edit_sec_q);
    end
  end

  // FSM state and registered outputs, decoded from the next state so the
  // first load beat appears on the cycle after the committing mode press.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q        <= 3'b111;  // a button held through reset is not a press
      state_q      <= RUN;
      edit_min_q   <= '0;
      edit_sec_q   <= '0;
      rep_q        <= '0;
      load_q       <= 1'b0;
      addrs_q      <= 2'b00;
      data_q       <= '0;
      editing_q    <= 1'b0;
      field_sel_q  <= 1'b0;
      edit_value_q <= '0;
`ifdef CLK_SET_CTRL_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      btn_q        <= btn;
      state_q      <= state_d;
      edit_min_q   <= edit_min_d;
      edit_sec_q   <= edit_sec_d;
      rep_q        <= rep_d;
`ifdef CLK_SET_CTRL_TIMEOUT_EN
      to_q         <= to_d;
`endif
      editing_q    <= (state_d == SET_MIN) || (state_d == SET_SEC);
      field_sel_q  <= (state_d == SET_SEC);
      edit_value_q <= (state_q == SET_SEC) ? edit_sec_q : edit_min_q;
      case (state_d)
        WR_MIN: begin
          load_q  <= 1'b1;
          addrs_q <= 2'b10;
          data_q  <= edit_min_d;
        end
        WR_SEC: begin
          load_q  <= 1'b1;
          addrs_q <= 2'b01;
          data_q  <= edit_sec_d;
        end
        WR_TB: begin
          load_q  <= 1'b1;
          addrs_q <= 2'b00;
          data_q  <= '0;
        end
        default: begin
          load_q  <= 1'b0;
          addrs_q <= 2'b00;
          data_q  <= '0;
        end
      endcase
    end
  end

  assign bus.load_out   = load_q;
  assign bus.addrs_out  = addrs_q;
  assign bus.data_out   = data_q;
  assign bus.editing    = editing_q;
  assign bus.field_sel  = field_sel_q;
  assign bus.edit_value = edit_value_q;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Bench for clk_set_ctrl: scenario tasks with an arithmetic model of the
// edit values (mod-60 stepping, hold-length -> step-count formula).
module tb_clk_set_ctrl;
  localparam int REP = 4;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clk_set_ctrl_if bus ();

  clk_set_ctrl #(.REPEAT_CYCLES(REP), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // model of the two edit fields
  int m_min, m_sec;

  // captured commit beats
  logic       cap_ld [3];
  logic [1:0] cap_ad [3];
  logic [5:0] cap_d  [3];
  logic       post_ld, post_ed;

  function automatic int up59(int v);  return (v == 59) ? 0 : v + 1; endfunction
  function automatic int dn59(int v);  return (v == 0) ? 59 : v - 1; endfunction
  function automatic int clamp(int v); return (v > 59) ? 59 : v;     endfunction
  // steps produced by holding one button for h sampled cycles
  function automatic int hold_steps(int h); return 1 + (h - 1) / REP; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 mode, 1 inc, 2 dec
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bus.btn_mode = v;
      1: bus.btn_inc  = v;
      default: bus.btn_dec = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick();
    set_btn(which, 1'b0);
    tick();
  endtask

  task automatic hold(input int which, input int h);
    set_btn(which, 1'b1);
    repeat (h) tick();
    set_btn(which, 1'b0);
    tick();
    tick();
  endtask

  // mode press in SET_SEC, recording the three following cycles
  task automatic commit();
    bus.btn_mode = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      bus.btn_mode = 1'b0;
      cap_ld[b] = bus.load_out;
      cap_ad[b] = bus.addrs_out;
      cap_d[b]  = bus.data_out;
    end
    tick();
    post_ld = bus.load_out;
    post_ed = bus.editing;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_mode = 1'b1; bus.btn_inc = 1'b1; bus.btn_dec = 1'b0;
    bus.minutes_in = 6'd5; bus.seconds_in = 6'd6;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    total++; if (bus.load_out !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", bus.load_out); end
    total++; if (bus.addrs_out !== 2'd0) begin bad++; $display("FAIL reset_addrs got=%0d exp=0", bus.addrs_out); end
    total++; if (bus.data_out !== 6'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", bus.data_out); end
    total++; if (bus.editing !== 1'b0) begin bad++; $display("FAIL reset_editing got=%b exp=0", bus.editing); end
    total++; if (bus.field_sel !== 1'b0) begin bad++; $display("FAIL reset_field got=%b exp=0", bus.field_sel); end
    total++; if (bus.edit_value !== 6'd0) begin bad++; $display("FAIL reset_value got=%0d exp=0", bus.edit_value); end
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    tick(); tick();
  endtask

  task automatic test_basic();
    int exp_ad[3];
    int exp_d[3];
    bus.minutes_in = 6'd12; bus.seconds_in = 6'd34;
    m_min = 12; m_sec = 34;
    press(0);
    total++; if (bus.editing !== 1'b1 || bus.field_sel !== 1'b0 || bus.edit_value !== 6'(m_min)) begin
      bad++; $display("FAIL basic_enter got=%b/%b/%0d exp=1/0/%0d", bus.editing, bus.field_sel, bus.edit_value, m_min); end
    repeat (3) begin press(1); m_min = up59(m_min); end
    total++; if (bus.edit_value !== 6'(m_min)) begin bad++; $display("FAIL basic_inc got=%0d exp=%0d", bus.edit_value, m_min); end
    press(0);
    total++; if (bus.field_sel !== 1'b1 || bus.edit_value !== 6'(m_sec)) begin
      bad++; $display("FAIL basic_sec got=%b/%0d exp=1/%0d", bus.field_sel, bus.edit_value, m_sec); end
    press(2); m_sec = dn59(m_sec);
    total++; if (bus.edit_value !== 6'(m_sec)) begin bad++; $display("FAIL basic_dec got=%0d exp=%0d", bus.edit_value, m_sec); end
    commit();
    exp_ad = '{2, 1, 0}; exp_d = '{m_min, m_sec, 0};
    for (int b = 0; b < 3; b++) begin
      total++; if (cap_ld[b] !== 1'b1 || cap_ad[b] !== 2'(exp_ad[b]) || cap_d[b] !== 6'(exp_d[b])) begin
        bad++; $display("FAIL basic_beat%0d got=%b/%0d/%0d exp=1/%0d/%0d", b, cap_ld[b], cap_ad[b], cap_d[b], exp_ad[b], exp_d[b]); end
    end
    total++; if (post_ld !== 1'b0 || post_ed !== 1'b0) begin bad++; $display("FAIL basic_after got=%b/%b exp=0/0", post_ld, post_ed); end
  endtask

  task automatic test_wrap();
    int exp_d[3];
    bus.minutes_in = 6'd59; bus.seconds_in = 6'd0;
    press(0);
    press(1);
    total++; if (bus.edit_value !== 6'd0) begin bad++; $display("FAIL wrap_inc got=%0d exp=0", bus.edit_value); end
    press(0);
    press(2);
    total++; if (bus.edit_value !== 6'd59) begin bad++; $display("FAIL wrap_dec got=%0d exp=59", bus.edit_value); end
    commit();
    exp_d = '{0, 59, 0};
    for (int b = 0; b < 3; b++) begin
      total++; if (cap_ld[b] !== 1'b1 || cap_d[b] !== 6'(exp_d[b])) begin
        bad++; $display("FAIL wrap_beat%0d got=%b/%0d exp=1/%0d", b, cap_ld[b], cap_d[b], exp_d[b]); end
    end
    // out-of-range seeds
    bus.minutes_in = 6'd63; bus.seconds_in = 6'd61;
    press(0);
    total++; if (bus.edit_value !== 6'd59) begin bad++; $display("FAIL clamp_min got=%0d exp=59", bus.edit_value); end
    press(0);
    total++; if (bus.edit_value !== 6'd59) begin bad++; $display("FAIL clamp_sec got=%0d exp=59", bus.edit_value); end
    commit();
    total++; if (cap_d[0] !== 6'd59 || cap_d[1] !== 6'd59) begin
      bad++; $display("FAIL clamp_beats got=%0d/%0d exp=59/59", cap_d[0], cap_d[1]); end
  endtask

  task automatic test_repeat();
    int h;
    bus.minutes_in = 6'd10; bus.seconds_in = 6'd5;
    m_min = 10; m_sec = 5;
    press(0);
    hold(1, 13);
    for (int i = 0; i < hold_steps(13); i++) m_min = up59(m_min);
    total++; if (bus.edit_value !== 6'(m_min)) begin bad++; $display("FAIL repeat_hold got=%0d exp=%0d", bus.edit_value, m_min); end
    repeat (5) tick();
    total++; if (bus.edit_value !== 6'(m_min)) begin bad++; $display("FAIL repeat_release got=%0d exp=%0d", bus.edit_value, m_min); end
    press(0);
    h = $urandom_range(20, 1);
    hold(2, h);
    for (int i = 0; i < hold_steps(h); i++) m_sec = dn59(m_sec);
    total++; if (bus.edit_value !== 6'(m_sec)) begin bad++; $display("FAIL repeat_dec h=%0d got=%0d exp=%0d", h, bus.edit_value, m_sec); end
    commit();
    total++; if (cap_d[0] !== 6'(m_min) || cap_d[1] !== 6'(m_sec)) begin
      bad++; $display("FAIL repeat_beats got=%0d/%0d exp=%0d/%0d", cap_d[0], cap_d[1], m_min, m_sec); end
  endtask

  task automatic test_simul();
    bus.minutes_in = 6'd20; bus.seconds_in = 6'd40;
    press(0);
    bus.btn_inc = 1'b1; bus.btn_dec = 1'b1;
    repeat (6) tick();
    bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
    tick(); tick();
    total++; if (bus.edit_value !== 6'd20) begin bad++; $display("FAIL simul_incdec got=%0d exp=20", bus.edit_value); end
    bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
    tick();
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    tick();
    total++; if (bus.field_sel !== 1'b1 || bus.edit_value !== 6'd40) begin
      bad++; $display("FAIL simul_mode got=%b/%0d exp=1/40", bus.field_sel, bus.edit_value); end
    commit();
    total++; if (cap_d[0] !== 6'd20 || cap_d[1] !== 6'd40) begin
      bad++; $display("FAIL simul_beats got=%0d/%0d exp=20/40", cap_d[0], cap_d[1]); end
  endtask

  task automatic test_reset_mid_write();
    bus.minutes_in = 6'd1; bus.seconds_in = 6'd2;
    press(0);
    press(0);
    bus.btn_mode = 1'b1;
    tick();
    bus.btn_mode = 1'b0;
    total++; if (bus.load_out !== 1'b1) begin bad++; $display("FAIL abort_first got=%b exp=1", bus.load_out); end
    reset = 1'b1;
    tick();
    total++; if (bus.load_out !== 1'b0) begin bad++; $display("FAIL abort_load got=%b exp=0", bus.load_out); end
    reset = 1'b0;
    tick(); tick();
    total++; if (bus.load_out !== 1'b0 || bus.editing !== 1'b0) begin
      bad++; $display("FAIL abort_after got=%b/%b exp=0/0", bus.load_out, bus.editing); end
  endtask

  task automatic test_timeout();
    logic seen;
    bus.minutes_in = 6'd7; bus.seconds_in = 6'd8;
    press(0);
    seen = 1'b0;
`ifdef CLK_SET_CTRL_TIMEOUT_EN
    repeat (12) begin tick(); if (bus.load_out) seen = 1'b1; end
    total++; if (bus.editing !== 1'b0 || seen !== 1'b0) begin
      bad++; $display("FAIL timeout_run got=%b/%b exp=0/0", bus.editing, seen); end
`else
    repeat (100) begin tick(); if (bus.load_out) seen = 1'b1; end
    total++; if (bus.editing !== 1'b1 || bus.field_sel !== 1'b0 || seen !== 1'b0) begin
      bad++; $display("FAIL no_timeout got=%b/%b/%b exp=1/0/0", bus.editing, bus.field_sel, seen); end
    press(0);
    commit();
    total++; if (cap_d[0] !== 6'd7 || cap_d[1] !== 6'd8) begin
      bad++; $display("FAIL no_timeout_beats got=%0d/%0d exp=7/8", cap_d[0], cap_d[1]); end
`endif
  endtask

  task automatic test_random();
    int nops, op, h;
    for (int it = 0; it < 20; it++) begin
      m_min = $urandom_range(63, 0); m_sec = $urandom_range(63, 0);
      bus.minutes_in = 6'(m_min); bus.seconds_in = 6'(m_sec);
      m_min = clamp(m_min); m_sec = clamp(m_sec);
      press(0);
      total++; if (bus.edit_value !== 6'(m_min)) begin bad++; $display("FAIL rnd%0d_seed got=%0d exp=%0d", it, bus.edit_value, m_min); end
      for (int f = 0; f < 2; f++) begin
        nops = $urandom_range(4, 0);
        for (int k = 0; k < nops; k++) begin
          op = $urandom_range(3, 0);
          h  = (op >= 2) ? $urandom_range(12, 1) : 1;
          if (op >= 2) hold(op - 1, h); else press(op + 1);
          for (int s = 0; s < hold_steps(h); s++) begin
            if (f == 0) m_min = (op % 2 == 0) ? up59(m_min) : dn59(m_min);
            else        m_sec = (op % 2 == 0) ? up59(m_sec) : dn59(m_sec);
          end
          total++; if (bus.edit_value !== 6'((f == 0) ? m_min : m_sec)) begin
            bad++; $display("FAIL rnd%0d_op got=%0d exp=%0d", it, bus.edit_value, (f == 0) ? m_min : m_sec); end
        end
        if (f == 0) press(0);
      end
      commit();
      total++; if (cap_ld[0] !== 1'b1 || cap_ad[0] !== 2'd2 || cap_d[0] !== 6'(m_min) ||
                   cap_ld[1] !== 1'b1 || cap_ad[1] !== 2'd1 || cap_d[1] !== 6'(m_sec) ||
                   cap_ld[2] !== 1'b1 || cap_ad[2] !== 2'd0 || cap_d[2] !== 6'd0) begin
        bad++; $display("FAIL rnd%0d_beats got=%0d/%0d/%0d exp=%0d/%0d/0", it, cap_d[0], cap_d[1], cap_d[2], m_min, m_sec); end
      total++; if (post_ed !== 1'b0) begin bad++; $display("FAIL rnd%0d_editing got=%b exp=0", it, post_ed); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_repeat();
    test_simul();
    test_reset_mid_write();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
